// File: rtl/conv_collect.sv
// conv_collect: binarizes conv results, buffers one feature map and replays it as a serial bit stream.
// Define COLLECT_POOL_EN to apply a 2x2 binary max-pool before storage.
module conv_collect #(
    parameter int W0     = 26,
    parameter int W1     = 8,
    parameter int DW     = 5,
    parameter int THRESH = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          state,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_done,
    input  logic          stream_go,
    output logic          frame_ready,
    output logic          out_start,
    output logic          out_valid,
    output logic          out_bit,
    output logic          out_last,
    output logic [9:0]    frame_len,
    output logic          err_len,
    output logic          err_ovr
);
`ifdef COLLECT_POOL_EN
    localparam int N0 = (W0 / 2) * (W0 / 2);
    localparam int N1 = (W1 / 2) * (W1 / 2);
`else
    localparam int N0 = W0 * W0;
    localparam int N1 = W1 * W1;
`endif
    localparam int DEPTH = N0 > N1 ? N0 : N1;
    localparam logic signed [DW-1:0] TH = DW'(THRESH);

    typedef enum logic [1:0] {CAPTURE, READY, STREAM} fsm_t;

    fsm_t       st, st_nx;
    logic       mem [DEPTH];
    logic [9:0] wr_ptr, rd_ptr, n, len_nx;
    logic       layer, busy, cur_layer, bit_in, take, full, wr_en, wr_bit, done;

    assign cur_layer = busy ? layer : state;
    assign n         = cur_layer ? 10'(N1) : 10'(N0);
    assign bit_in    = $signed(in_data) >= TH;
    assign take      = st == CAPTURE && in_valid;
    assign done      = take && in_done;
    assign len_nx    = wr_ptr + {9'd0, wr_en};

`ifdef COLLECT_POOL_EN
    localparam int WM = W0 > W1 ? W0 : W1;
    localparam int CW = $clog2(WM + 1);
    localparam int RB = WM / 2 > 0 ? WM / 2 : 1;

    logic [CW-1:0] col, row, w;
    logic [RB-1:0] rb;
    logic          hbit, pair;

    assign w      = cur_layer ? CW'(W1) : CW'(W0);
    assign full   = row >= w;
    assign pair   = hbit | bit_in;
    assign wr_bit = pair | rb[col[CW-1:1]];
    assign wr_en  = take && !full && row[0] && col[0];

    // Even rows park their horizontal pair ORs; odd rows merge and store.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col  <= '0;
            row  <= '0;
            hbit <= 1'b0;
            rb   <= '0;
        end else if (done) begin
            col <= '0;
            row <= '0;
        end else if (take && !full) begin
            if (!col[0]) hbit <= bit_in;
            if (!row[0] && col[0]) rb[col[CW-1:1]] <= pair;
            if (col == w - CW'(1)) begin
                col <= '0;
                row <= row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end
`else
    assign full   = wr_ptr >= n;
    assign wr_bit = bit_in;
    assign wr_en  = take && !full;
`endif

    always_ff @(posedge clk) if (wr_en) mem[wr_ptr] <= wr_bit;

    always_comb begin
        st_nx = st;
        if (st == CAPTURE && done && len_nx != 10'd0) st_nx = READY;
        if (st == READY && stream_go) st_nx = STREAM;
        if (out_last) st_nx = CAPTURE;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st        <= CAPTURE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_len <= '0;
            layer     <= 1'b0;
            busy      <= 1'b0;
            err_len   <= 1'b0;
            err_ovr   <= 1'b0;
        end else begin
            st <= st_nx;
            if (take) begin
                busy <= 1'b1;
                if (!busy) layer <= state;
            end
            if (wr_en) wr_ptr <= wr_ptr + 10'd1;
            if (take && full) err_len <= 1'b1;
            if (done) begin
                frame_len <= len_nx;
                busy      <= 1'b0;
                wr_ptr    <= '0;
                if (len_nx != n) err_len <= 1'b1;
            end
            if (in_valid && st != CAPTURE) err_ovr <= 1'b1;
            rd_ptr <= st == STREAM ? rd_ptr + 10'd1 : '0;
        end
    end

    assign frame_ready = st == READY;
    assign out_valid   = st == STREAM;
    assign out_start   = out_valid && rd_ptr == 10'd0;
    assign out_last    = out_valid && rd_ptr == frame_len - 10'd1;
    assign out_bit     = out_valid && mem[rd_ptr];
endmodule
